// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register bridge.
// Defining SPI_REG_BRIDGE_AUTOINC_EN makes the address advance after every data byte.
package spi_reg_pkg;

  localparam int CMD_WR_BIT = 7;
  localparam int ADDR_W     = 7;
  localparam int REG_W      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  // Next address after a data byte; fixed-address mode keeps polling the same register.
  function automatic logic [ADDR_W-1:0] addr_advance(input logic [ADDR_W-1:0] addr);
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
    return addr + 7'd1;
`else
    return addr;
`endif
  endfunction

endpackage

// File: rtl/spi_cs_frame_detect.sv
// Chip-select synchronizer with two extra delay stages; pulses once per CS rising edge,
// late enough that the final received byte of the frame is always seen first.
module spi_cs_frame_detect (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_SPI_CS_n,
  output logic o_Frame_End
);

  logic cs_meta_r;
  logic cs_sync_r;
  logic cs_dly1_r;
  logic cs_dly2_r;

  // Synchronize the raw pin and delay it two more cycles; all stages idle high.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      cs_meta_r <= 1'b1;
      cs_sync_r <= 1'b1;
      cs_dly1_r <= 1'b1;
      cs_dly2_r <= 1'b1;
    end else begin
      cs_meta_r <= i_SPI_CS_n;
      cs_sync_r <= cs_meta_r;
      cs_dly1_r <= cs_sync_r;
      cs_dly2_r <= cs_dly1_r;
    end
  end

  assign o_Frame_End = cs_dly1_r & ~cs_dly2_r;

endmodule

// File: rtl/spi_reg_bridge.sv
// Byte-level command decoder and register bank behind the SPI slave.
// Address auto-increment is enabled by defining SPI_REG_BRIDGE_AUTOINC_EN.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int          NUM_REGS  = 16,
  parameter logic [7:0]  IDLE_BYTE = 8'hA5
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_L,
  input  logic                      i_RX_DV,
  input  logic [7:0]                i_RX_Byte,
  input  logic                      i_SPI_CS_n,
  output logic                      o_TX_DV,
  output logic [7:0]                o_TX_Byte,
  output logic [8*NUM_REGS-1:0]     o_Regs,
  output logic                      o_Wr_Strobe,
  output logic [6:0]                o_Wr_Addr,
  output logic [7:0]                o_Wr_Data,
  output logic                      o_Busy
);

  state_e                    state_r;
  logic [ADDR_W-1:0]         addr_r;
  logic [REG_W*NUM_REGS-1:0] regs_r;
  logic                      init_done_r;
  logic                      tx_dv_r;
  logic [REG_W-1:0]          tx_byte_r;
  logic                      wr_strobe_r;
  logic [ADDR_W-1:0]         wr_addr_r;
  logic [REG_W-1:0]          wr_data_r;
  logic                      busy_r;
  logic                      frame_end_s;
  logic [ADDR_W-1:0]         rd_addr_s;
  logic [REG_W-1:0]          rd_data_s;

  spi_cs_frame_detect u_frame_detect (
    .i_Clk       (i_Clk),
    .i_Rst_L     (i_Rst_L),
    .i_SPI_CS_n  (i_SPI_CS_n),
    .o_Frame_End (frame_end_s)
  );

  // Read mux: the command byte supplies the address on READ entry, addr_r afterwards.
  always_comb begin
    rd_addr_s = (state_r == IDLE) ? i_RX_Byte[ADDR_W-1:0] : addr_r;
    rd_data_s = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_data_s = (rd_addr_s == ADDR_W'(i)) ? regs_r[REG_W*i +: REG_W] : rd_data_s;
    end
  end

  // Transaction FSM, register bank and all registered outputs.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_r     <= IDLE;
      addr_r      <= 7'd0;
      regs_r      <= {(REG_W*NUM_REGS){1'b0}};
      init_done_r <= 1'b0;
      tx_dv_r     <= 1'b0;
      tx_byte_r   <= 8'h00;
      wr_strobe_r <= 1'b0;
      wr_addr_r   <= 7'd0;
      wr_data_r   <= 8'h00;
      busy_r      <= 1'b0;
    end else begin
      tx_dv_r     <= 1'b0;
      wr_strobe_r <= 1'b0;
      if (!init_done_r) begin
        init_done_r <= 1'b1;
        tx_dv_r     <= 1'b1;
        tx_byte_r   <= IDLE_BYTE;
      end
      if (i_RX_DV) begin
        case (state_r)
          IDLE: begin
            busy_r <= 1'b1;
            if (i_RX_Byte[CMD_WR_BIT]) begin
              state_r <= WRITE;
              addr_r  <= i_RX_Byte[ADDR_W-1:0];
            end else begin
              state_r   <= READ;
              tx_byte_r <= rd_data_s;
              tx_dv_r   <= 1'b1;
              addr_r    <= addr_advance(i_RX_Byte[ADDR_W-1:0]);
            end
          end
          WRITE: begin
            // Out-of-range addresses match no register but still strobe.
            for (int i = 0; i < NUM_REGS; i++) begin
              if (addr_r == ADDR_W'(i)) begin
                regs_r[REG_W*i +: REG_W] <= i_RX_Byte;
              end
            end
            wr_strobe_r <= 1'b1;
            wr_addr_r   <= addr_r;
            wr_data_r   <= i_RX_Byte;
            addr_r      <= addr_advance(addr_r);
          end
          READ: begin
            tx_byte_r <= rd_data_s;
            tx_dv_r   <= 1'b1;
            addr_r    <= addr_advance(addr_r);
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
      // End of frame overrides any TX load from a coincident byte.
      if (frame_end_s) begin
        state_r   <= IDLE;
        busy_r    <= 1'b0;
        tx_dv_r   <= 1'b1;
        tx_byte_r <= IDLE_BYTE;
      end
    end
  end

  assign o_TX_DV     = tx_dv_r;
  assign o_TX_Byte   = tx_byte_r;
  assign o_Regs      = regs_r;
  assign o_Wr_Strobe = wr_strobe_r;
  assign o_Wr_Addr   = wr_addr_r;
  assign o_Wr_Data   = wr_data_r;
  assign o_Busy      = busy_r;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: transaction-level model plus directed literal checks.
module tb_spi_reg_bridge;

  localparam int NR = 16;
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
  localparam int AUTO = 1;
`else
  localparam int AUTO = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic          cs_n;
  logic          tx_dv;
  logic [7:0]    tx_byte;
  logic [8*NR-1:0] regs;
  logic          wr_stb;
  logic [6:0]    wr_addr;
  logic [7:0]    wr_data;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // model state
  logic [7:0] m_regs [0:127];
  int         m_mode;        // 0 idle, 1 write, 2 read
  logic [6:0] m_addr;
  logic       m_init;
  logic       m_tx_dv;
  logic [7:0] m_tx_byte;
  logic       m_wr_stb;
  logic [6:0] m_wr_addr;
  logic [7:0] m_wr_data;
  logic       cs_hist [0:4];
  logic       m_valid = 1'b0;

  spi_reg_bridge #(.NUM_REGS(NR), .IDLE_BYTE(8'hA5)) dut (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_RX_DV     (rx_dv),
    .i_RX_Byte   (rx_byte),
    .i_SPI_CS_n  (cs_n),
    .o_TX_DV     (tx_dv),
    .o_TX_Byte   (tx_byte),
    .o_Regs      (regs),
    .o_Wr_Strobe (wr_stb),
    .o_Wr_Addr   (wr_addr),
    .o_Wr_Data   (wr_data),
    .o_Busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_rd(input logic [6:0] a);
    return (a < 7'(NR)) ? m_regs[a] : 8'h00;
  endfunction

  function automatic logic [8*NR-1:0] m_packed();
    logic [8*NR-1:0] v;
    for (int n = 0; n < NR; n++) v[8*n +: 8] = m_regs[n];
    return v;
  endfunction

  // Reference behaviour for one clock edge, from the bench's own input values.
  task automatic model_step();
    logic eof;
    logic [6:0] step;
    step = (AUTO != 0) ? 7'd1 : 7'd0;
    for (int i = 4; i > 0; i--) cs_hist[i] = cs_hist[i-1];
    cs_hist[0] = cs_n;
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) cs_hist[i] = 1'b1;
      for (int i = 0; i < 128; i++) m_regs[i] = 8'h00;
      m_mode = 0; m_addr = 7'd0; m_init = 1'b0;
      m_tx_dv = 1'b0; m_tx_byte = 8'h00; m_wr_stb = 1'b0;
      m_wr_addr = 7'd0; m_wr_data = 8'h00;
    end else begin
      eof = cs_hist[3] & ~cs_hist[4];
      m_tx_dv = 1'b0;
      m_wr_stb = 1'b0;
      if (!m_init) begin
        m_init = 1'b1; m_tx_dv = 1'b1; m_tx_byte = 8'hA5;
      end
      if (rx_dv) begin
        if (m_mode == 0) begin
          m_addr = rx_byte[6:0];
          if (rx_byte[7]) m_mode = 1;
          else begin
            m_mode = 2; m_tx_dv = 1'b1; m_tx_byte = m_rd(m_addr); m_addr = m_addr + step;
          end
        end else if (m_mode == 1) begin
          if (m_addr < 7'(NR)) m_regs[m_addr] = rx_byte;
          m_wr_stb = 1'b1; m_wr_addr = m_addr; m_wr_data = rx_byte;
          m_addr = m_addr + step;
        end else begin
          m_tx_dv = 1'b1; m_tx_byte = m_rd(m_addr); m_addr = m_addr + step;
        end
      end
      if (eof) begin
        m_mode = 0; m_tx_dv = 1'b1; m_tx_byte = 8'hA5;
      end
    end
    m_valid = 1'b1;
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("tx_dv", {31'd0, tx_dv}, {31'd0, m_tx_dv});
      chk("tx_byte", {24'd0, tx_byte}, {24'd0, m_tx_byte});
      chk("wr_stb", {31'd0, wr_stb}, {31'd0, m_wr_stb});
      chk("wr_addr", {25'd0, wr_addr}, {25'd0, m_wr_addr});
      chk("wr_data", {24'd0, wr_data}, {24'd0, m_wr_data});
      chk("busy", {31'd0, busy}, {31'd0, (m_mode != 0)});
      checks++;
      if (regs !== m_packed()) begin
        errors++;
        $display("FAIL regs actual=%0h expected=%0h at %0t", regs, m_packed(), $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input logic [7:0] b);
    rx_dv = 1'b1; rx_byte = b;
    tick();
    rx_dv = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    pulse(b);
    idle(int'($urandom_range(2, 6)));
  endtask

  task automatic end_frame();
    idle(2);
    cs_n = 1'b1;
    idle(8);
  endtask

  initial begin
    int nb;
    logic [7:0] cmd;
    rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; cs_n = 1'b1;
    idle(2);
    rst_n = 1'b1;
    tick();
    chk("init_txdv", {31'd0, tx_dv}, 32'd1);
    chk("init_txbyte", {24'd0, tx_byte}, 32'hA5);
    chk("init_regs", {31'd0, (regs == '0)}, 32'd1);
    chk("init_busy", {31'd0, busy}, 32'd0);
    idle(3);

    // write burst 82, 11, 22
    cs_n = 1'b0; idle(2);
    pulse(8'h82); idle(3);
    pulse(8'h11);
    chk("wr1_stb", {31'd0, wr_stb}, 32'd1);
    chk("wr1_addr", {25'd0, wr_addr}, 32'd2);
    chk("wr1_data", {24'd0, wr_data}, 32'h11);
    idle(3);
    pulse(8'h22);
    chk("wr2_addr", {25'd0, wr_addr}, (AUTO != 0) ? 32'd3 : 32'd2);
    end_frame();
    chk("reg2", {24'd0, regs[23:16]}, (AUTO != 0) ? 32'h11 : 32'h22);
    chk("reg3", {24'd0, regs[31:24]}, (AUTO != 0) ? 32'h22 : 32'h00);
    chk("eof_busy", {31'd0, busy}, 32'd0);
    chk("eof_tx", {24'd0, tx_byte}, 32'hA5);

    // read burst from 2
    cs_n = 1'b0; idle(2);
    pulse(8'h02);
    chk("rd0_dv", {31'd0, tx_dv}, 32'd1);
    chk("rd0_byte", {24'd0, tx_byte}, (AUTO != 0) ? 32'h11 : 32'h22);
    chk("rd0_busy", {31'd0, busy}, 32'd1);
    idle(3);
    pulse(8'h00);
    chk("rd1_byte", {24'd0, tx_byte}, 32'h22);
    end_frame();

    // out-of-range write and wrap
    cs_n = 1'b0; idle(2);
    pulse(8'hFF); idle(3);
    pulse(8'h55);
    chk("oor_stb", {31'd0, wr_stb}, 32'd1);
    chk("oor_addr", {25'd0, wr_addr}, 32'd127);
    idle(3);
    pulse(8'h66);
    chk("wrap_addr", {25'd0, wr_addr}, (AUTO != 0) ? 32'd0 : 32'd127);
    chk("wrap_reg0", {24'd0, regs[7:0]}, (AUTO != 0) ? 32'h66 : 32'h00);
    end_frame();

    // byte coincident with end-of-frame
    cs_n = 1'b0; idle(2);
    pulse(8'h85); idle(3);
    pulse(8'hAA); idle(3);
    cs_n = 1'b1; idle(3);
    pulse(8'h3C);
    chk("coin_busy", {31'd0, busy}, 32'd0);
    chk("coin_dv", {31'd0, tx_dv}, 32'd1);
    chk("coin_tx", {24'd0, tx_byte}, 32'hA5);
    chk("coin_reg", {24'd0, (AUTO != 0) ? regs[55:48] : regs[47:40]}, 32'h3C);
    idle(6);

    // reset in the middle of a read burst
    cs_n = 1'b0; idle(2);
    pulse(8'h02); idle(3);
    pulse(8'h00); idle(2);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rst_regs", {31'd0, (regs == '0)}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("rst_tx", {24'd0, tx_byte}, 32'hA5);
    idle(2);
    pulse(8'h84);
    chk("rst_cmd_busy", {31'd0, busy}, 32'd1);
    idle(3);
    pulse(8'h77);
    chk("rst_wr_addr", {25'd0, wr_addr}, 32'd4);
    chk("rst_reg4", {24'd0, regs[39:32]}, 32'h77);
    end_frame();

    // randomized frames
    for (int f = 0; f < 60; f++) begin
      cmd[7] = 1'($urandom_range(0, 1));
      cmd[6:0] = ($urandom_range(0, 7) == 0) ? 7'(120 + $urandom_range(0, 7))
                                             : 7'($urandom_range(0, 19));
      nb = int'($urandom_range(1, 5));
      cs_n = 1'b0; idle(int'($urandom_range(1, 3)));
      send(cmd);
      for (int b = 0; b < nb; b++) send(8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        cs_n = 1'b1; idle(3);
        pulse(8'($urandom));
        idle(6);
      end else begin
        end_frame();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
